playback: RTL

- Reads back the 1-bit-per-slot key pattern stored in RecordMemory by the recorder.
- Replays it at the same slot rate, emitting one trigger pulse per recorded "key pressed" slot to the sound engine.
- Sits on the read side of the record memory. It drives the memory address and consumes q once recording is done.
- Supports single-shot or looped playback, with abort.

---
 rtl/midi_pkg.sv | 16 +
 rtl/slot_timer.sv | 30 +++
 rtl/playback.sv | 114 +++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared constants and types for the key recorder / playback pair.
// Record and playback must agree on slot rate and memory depth.
package midi_pkg;

   localparam int ADDR_W           = 8;
   localparam int DEF_MAX_ADDR     = 128;
   localparam int DEF_SLOT_CYCLES  = 12500000;
   localparam int DEF_PULSE_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE,
      SLOT,
      DONE
   } pb_state_t;

endpackage

// File: rtl/slot_timer.sv
// Free-running slot counter 0..SLOT_CYCLES-1 with synchronous clear.
// tick marks the last cycle of a slot while enabled.
module slot_timer #(
   parameter int SLOT_CYCLES = midi_pkg::DEF_SLOT_CYCLES,
   parameter int CNT_W       = $clog2(SLOT_CYCLES)
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             tick
);
   import midi_pkg::*;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_CYCLES - 1);

   assign tick = en && (count == LAST);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/playback.sv
// Replays the recorded 1-bit-per-slot key pattern from RecordMemory,
// emitting a fixed-length trigger pulse for every slot that holds a 1.
module playback #(
   parameter int ADDR_W       = midi_pkg::ADDR_W,
   parameter int MAX_ADDR     = midi_pkg::DEF_MAX_ADDR,
   parameter int SLOT_CYCLES  = midi_pkg::DEF_SLOT_CYCLES,
   parameter int PULSE_CYCLES = midi_pkg::DEF_PULSE_CYCLES
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              play,
   input  logic              stop,
   input  logic              loop,
   input  logic              rec_done,
   input  logic              mem_q,
   output logic [ADDR_W-1:0] mem_address,
   output logic              trigger,
   output logic              playing,
   output logic              done,
   output logic [ADDR_W-1:0] slot
);
   import midi_pkg::*;

   localparam int               CNT_W      = $clog2(SLOT_CYCLES);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAX_ADDR);
   localparam logic [CNT_W-1:0]  SAMPLE_AT  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  PULSE_FROM = CNT_W'(2);
   localparam logic [CNT_W-1:0]  PULSE_TO   = CNT_W'(2 + PULSE_CYCLES);

   pb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] addr_d;
   logic              play_d;
   logic              sample_q;
   logic              trigger_d;
   logic              start, abort;
   logic              tmr_clr, tmr_en, tick;
   logic [CNT_W-1:0]  cnt;

   slot_timer #(
      .SLOT_CYCLES (SLOT_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .clr      (tmr_clr),
      .en       (tmr_en),
      .count    (cnt),
      .tick     (tick)
   );

   always_comb begin
      start     = play & ~play_d;
      abort     = stop | ((state_q == SLOT) & ~rec_done);
      state_d   = state_q;
      addr_d    = mem_address;
      trigger_d = 1'b0;
      tmr_en    = (state_q == SLOT);
      tmr_clr   = abort | (state_q != SLOT);

      if (abort) begin
         state_d = IDLE;
         addr_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && rec_done) begin
                  state_d = SLOT;
                  addr_d  = '0;
               end
            end
            SLOT: begin
               // sample_q was captured at count 1; pulse spans counts PULSE_FROM+1..PULSE_TO
               trigger_d = sample_q && (cnt >= PULSE_FROM) && (cnt < PULSE_TO);
               if (tick) begin
                  if (mem_address != LAST_ADDR) begin
                     addr_d = mem_address + 1'b1;
                  end else if (loop) begin
                     addr_d = '0;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (!play) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_address <= '0;
         play_d      <= 1'b0;
         sample_q    <= 1'b0;
         trigger     <= 1'b0;
         playing     <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_address <= addr_d;
         play_d      <= play;
         if ((state_q == SLOT) && (cnt == SAMPLE_AT)) sample_q <= mem_q;
         trigger     <= trigger_d;
         playing     <= (state_d == SLOT);
         done        <= (state_d == DONE);
      end
   end

   assign slot = mem_address;

endmodule
